crc8_framer: RTL and testbench
==============================

# crc8_framer

Upstream companion to the `crc8` engine. It accepts a byte-stream frame on a valid/ready/last input port and forwards every payload byte to a registered output port. It feeds each accepted byte to a `crc8` instance and, after the last payload byte, appends the resulting CRC-8 as the final beat of the frame. It drives the engine's data, valid and clear inputs and reads its CRC output, so it needs no CRC logic of its own.

## Interface
- `COUNT_WIDTH`, default 16, width of the sent-frame counter.
- `clk_i` input 1: single clock; all state is on its rising edge.
- `rst_ni` input 1: asynchronous, active-low reset.
- `s_data_i` input 8: payload byte.
- `s_valid_i` input 1: payload byte valid.
- `s_last_i` input 1: marks the final payload byte of a frame.
- `s_ready_o` output 1: framer accepts a byte this cycle.
- `m_data_o` output 8: output byte (payload or CRC).
- `m_valid_o` output 1: output beat valid.
- `m_last_o` output 1: beat is the CRC byte that ends the frame.
- `m_ready_i` input 1: downstream accepts the beat.
- `crc_data_o` output 8: to the engine's `data_i`.
- `crc_valid_o` output 1: to the engine's `data_valid_i`.
- `crc_clear_o` output 1: to the engine's `rst_i`.
- `crc_i` input 8: from the engine's `crc_o`.
- `frame_count_o` output COUNT_WIDTH: number of frames whose CRC beat has been loaded.

## Operation
- The block has one output register holding `m_data_o`, `m_last_o` and `m_valid_o`.
  - It is free when `!m_valid_o || m_ready_i`.
  - When a beat is handed off and nothing new is loaded, `m_valid_o` clears.
- **INIT** is the reset state.
  - Outputs: `crc_clear_o` = 1, `s_ready_o` = 0.
  - Goes unconditionally to PAYLOAD on the first clock after `rst_ni` rises.
- **PAYLOAD**
  - `s_ready_o` = output register free.
  - Accept = `s_valid_i && s_ready_o`.
  - On accept:
    - The output register loads `s_data_i` with `m_last_o` = 0.
    - `crc_valid_o` = 1 and `crc_data_o` = `s_data_i`, both combinational in the same cycle.
  - An accept with `s_last_i` = 1 goes to CRC.
  - Otherwise the state stays in PAYLOAD.
- **CRC**
  - `s_ready_o` = 0.
  - When the output register is free:
    - The register loads `crc_i` with `m_last_o` = 1.
    - `crc_clear_o` = 1 for that cycle.
    - `frame_count_o` increments, wrapping modulo 2^COUNT_WIDTH.
    - The state goes to PAYLOAD.
  - Otherwise the state holds in CRC. `crc_i` stays stable because the engine holds its saved value until cleared.
- Outside the cases above, `crc_valid_o` = 0, `crc_clear_o` = 0 and `crc_data_o` = `s_data_i`.
- A one-byte frame is legal: byte, then CRC.
- A zero-length frame cannot occur, since `s_last_i` always travels with a byte.
- Frame length is unbounded.
- Mid-frame reset:
  - The partial frame is discarded.
  - `m_valid_o` drops asynchronously.
  - The engine is cleared while in INIT.
  - No CRC beat is emitted.

## Timing
- Reset values:
  - `m_valid_o`, `m_last_o`, `m_data_o`, `frame_count_o`: 0.
  - `s_ready_o`: 0.
  - `crc_valid_o`: 0.
  - `crc_clear_o`: 1.
- Latency: a byte accepted at edge t is on `m_data_o` from cycle t+1.
- CRC timing: the last byte is accepted at cycle t; the engine's `crc_i` is valid from t+1; the CRC beat is loaded at t+1 if the output register is free.
- The clear cycle (CRC state) never accepts input. The first byte of the next frame is accepted no earlier than the cycle after the clear, when the engine's `crc_o` = 0.
- With `m_ready_i` held at 1, an N-byte frame occupies exactly N+1 cycles, and the output is 100% utilised.
- Downstream stall (`m_ready_i` = 0 with `m_valid_o` = 1):
  - `s_ready_o` = 0.
  - Output data, last and valid hold stable.
  - No byte is dropped or duplicated.
- Input `s_valid_i` may drop between bytes. `crc_valid_o` follows accepts only.

## Test plan
- Reset release with `s_valid_i` high:
  - INIT cycle has `crc_clear_o` = 1 and `s_ready_o` = 0.
  - First accept happens one cycle later.
  - All outputs read 0 during reset.
- Frame "123456789" (0x31..0x39), `m_ready_i` = 1, bench `crc8` with POLYNOMIAL 0x07:
  - Output is 9 payload beats, then 0xF4 with `m_last_o` = 1.
  - The frame takes 10 cycles.
  - `frame_count_o` goes 0→1.
- Back-to-back one-byte frames 0xFF, 0x01, 0x00:
  - Output beats: FF, F3(last), 01, 07(last), 00, 00(last).
  - Each CRC is unaffected by the previous frame.
- Random `m_ready_i` (50%) and random `s_valid_i` gaps over 200 random frames:
  - Every output byte and `m_last_o` matches a reference-model CRC.
  - No loss or duplication occurs.
  - `m_data_o` is stable while stalled.
- Stall in CRC state: hold `m_ready_i` = 0 for 5 cycles after the last byte.
  - The CRC beat is still correct.
  - `crc_clear_o` pulses exactly once, on the load cycle.
- `rst_ni` asserted after 3 bytes of a 6-byte frame:
  - `m_valid_o` drops immediately.
  - After release, a new frame 0x01 yields CRC 0x07.

Source files
------------

// File: rtl/crc8_framer.sv
// crc8_framer: forwards a valid/ready/last byte stream to a registered output
// port and appends the CRC-8 produced by an external crc8 engine as the final
// beat of each frame. The engine is driven through crc_data_o/crc_valid_o/
// crc_clear_o and its result is read back on crc_i.
module crc8_framer #(
   parameter int COUNT_WIDTH = 16
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic [7:0]             s_data_i,
   input  logic                   s_valid_i,
   input  logic                   s_last_i,
   output logic                   s_ready_o,
   output logic [7:0]             m_data_o,
   output logic                   m_valid_o,
   output logic                   m_last_o,
   input  logic                   m_ready_i,
   output logic [7:0]             crc_data_o,
   output logic                   crc_valid_o,
   output logic                   crc_clear_o,
   input  logic [7:0]             crc_i,
   output logic [COUNT_WIDTH-1:0] frame_count_o
);

   typedef enum logic [1:0] {
      ST_INIT    = 2'd0,
      ST_PAYLOAD = 2'd1,
      ST_CRC     = 2'd2
   } state_t;

   state_t                 r_state;
   logic [7:0]             r_m_data;
   logic                   r_m_last;
   logic                   r_m_valid;
   logic [COUNT_WIDTH-1:0] r_frame_count;

   logic w_out_free;
   logic w_s_ready;
   logic w_accept;
   logic w_crc_load;
   logic w_crc_clear;

   // Handshake and engine-control decode; engine controls must be
   // combinational so the engine sees each byte in the cycle it is accepted.
   always_comb begin
      w_out_free  = (!r_m_valid) || m_ready_i;
      w_s_ready   = 1'b0;
      w_crc_load  = 1'b0;
      w_crc_clear = 1'b0;
      case (r_state)
         ST_INIT: begin
            w_crc_clear = 1'b1;
         end
         ST_PAYLOAD: begin
            w_s_ready = w_out_free;
         end
         ST_CRC: begin
            // Loading the CRC beat and clearing the engine share one cycle.
            w_crc_load  = w_out_free;
            w_crc_clear = w_out_free;
         end
         default: begin
            w_crc_clear = 1'b1;
         end
      endcase
      w_accept = s_valid_i && w_s_ready;
   end

   // Frame FSM, output beat register and sent-frame counter.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state       <= ST_INIT;
         r_m_data      <= 8'h00;
         r_m_last      <= 1'b0;
         r_m_valid     <= 1'b0;
         r_frame_count <= '0;
      end else begin
         case (r_state)
            ST_INIT: begin
               r_state   <= ST_PAYLOAD;
               r_m_valid <= 1'b0;
            end
            ST_PAYLOAD: begin
               if (w_accept) begin
                  r_m_data  <= s_data_i;
                  r_m_last  <= 1'b0;
                  r_m_valid <= 1'b1;
                  if (s_last_i) begin
                     r_state <= ST_CRC;
                  end else begin
                     r_state <= ST_PAYLOAD;
                  end
               end else if (m_ready_i) begin
                  // Beat handed off with nothing new to load.
                  r_m_valid <= 1'b0;
               end else begin
                  r_m_valid <= r_m_valid;
               end
            end
            ST_CRC: begin
               if (w_crc_load) begin
                  // crc_i is stable here: the engine holds its result until cleared.
                  r_m_data      <= crc_i;
                  r_m_last      <= 1'b1;
                  r_m_valid     <= 1'b1;
                  r_frame_count <= r_frame_count + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
                  r_state       <= ST_PAYLOAD;
               end else begin
                  r_state <= ST_CRC;
               end
            end
            default: begin
               r_state   <= ST_INIT;
               r_m_valid <= 1'b0;
            end
         endcase
      end
   end

   assign s_ready_o     = w_s_ready;
   assign m_data_o      = r_m_data;
   assign m_last_o      = r_m_last;
   assign m_valid_o     = r_m_valid;
   assign crc_data_o    = s_data_i;
   assign crc_valid_o   = w_accept;
   assign crc_clear_o   = w_crc_clear;
   assign frame_count_o = r_frame_count;

endmodule

// File: tb/tb_crc8_framer.sv
// Self-checking bench for crc8_framer with a behavioural crc8 engine
// (POLYNOMIAL 0x07, initial value 0x00).
module tb_crc8_framer;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic [7:0]  s_data_i;
   logic        s_valid_i;
   logic        s_last_i;
   logic        s_ready_o;
   logic [7:0]  m_data_o;
   logic        m_valid_o;
   logic        m_last_o;
   logic        m_ready_i;
   logic [7:0]  crc_data_o;
   logic        crc_valid_o;
   logic        crc_clear_o;
   logic [7:0]  crc_i;
   logic [15:0] frame_count_o;

   int n_checks = 0;
   int n_fail   = 0;

   crc8_framer #(.COUNT_WIDTH(16)) dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .s_data_i      (s_data_i),
      .s_valid_i     (s_valid_i),
      .s_last_i      (s_last_i),
      .s_ready_o     (s_ready_o),
      .m_data_o      (m_data_o),
      .m_valid_o     (m_valid_o),
      .m_last_o      (m_last_o),
      .m_ready_i     (m_ready_i),
      .crc_data_o    (crc_data_o),
      .crc_valid_o   (crc_valid_o),
      .crc_clear_o   (crc_clear_o),
      .crc_i         (crc_i),
      .frame_count_o (frame_count_o)
   );

   // Clock generation.
   always #5 clk_i = ~clk_i;

   function automatic logic [7:0] crc8_upd(input logic [7:0] c, input logic [7:0] d);
      logic [7:0] x;
      x = c ^ d;
      for (int i = 0; i < 8; i++) begin
         x = x[7] ? ((x << 1) ^ 8'h07) : (x << 1);
      end
      return x;
   endfunction

   // Behavioural crc8 engine: synchronous clear, update on data valid.
   logic [7:0] eng_crc = 8'h00;
   always @(posedge clk_i) begin
      if (crc_clear_o) eng_crc <= 8'h00;
      else if (crc_valid_o) eng_crc <= crc8_upd(eng_crc, crc_data_o);
   end
   assign crc_i = eng_crc;

   // Watchdog so the run always terminates.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   typedef struct packed {
      logic        v;
      logic [7:0]  d;
      logic        l;
      logic        r;
      logic        e_rdy;
      logic        e_cv;
      logic        e_clr;
      logic        e_mv;
      logic [7:0]  e_md;
      logic        e_ml;
      logic [15:0] e_cnt;
   } vec_t;

   vec_t tv[$];

   task automatic add(input logic v, input logic [7:0] d, input logic l, input logic r,
                      input logic e_rdy, input logic e_cv, input logic e_clr, input logic e_mv,
                      input logic [7:0] e_md, input logic e_ml, input logic [15:0] e_cnt);
      vec_t e;
      e = '{v, d, l, r, e_rdy, e_cv, e_clr, e_mv, e_md, e_ml, e_cnt};
      tv.push_back(e);
   endtask

   initial begin
      logic [8:0] sb[$];
      logic [8:0] beat;
      logic [7:0] rcrc;
      logic [7:0] prev_d;
      logic       prev_l;
      logic       prev_stall;
      logic       acc;
      int         rem;
      int         frames_driven;
      int         cycles;
      int         clr_pulses;

      // Frame "123456789" then one-byte frames FF, 01, 00, m_ready held high.
      add(1'b1, 8'h31, 1'b0, 1'b1,  1'b1, 1'b1, 1'b0,  1'b0, 8'h00, 1'b0, 16'd0);
      for (int k = 1; k <= 8; k++) begin
         add(1'b1, 8'(8'h31 + k), (k == 8), 1'b1,  1'b1, 1'b1, 1'b0,  1'b1, 8'(8'h30 + k), 1'b0, 16'd0);
      end
      add(1'b1, 8'hAA, 1'b0, 1'b1,  1'b0, 1'b0, 1'b1,  1'b1, 8'h39, 1'b0, 16'd0);
      add(1'b1, 8'hFF, 1'b1, 1'b1,  1'b1, 1'b1, 1'b0,  1'b1, 8'hF4, 1'b1, 16'd1);
      add(1'b1, 8'h01, 1'b1, 1'b1,  1'b0, 1'b0, 1'b1,  1'b1, 8'hFF, 1'b0, 16'd1);
      add(1'b1, 8'h01, 1'b1, 1'b1,  1'b1, 1'b1, 1'b0,  1'b1, 8'hF3, 1'b1, 16'd2);
      add(1'b1, 8'h00, 1'b1, 1'b1,  1'b0, 1'b0, 1'b1,  1'b1, 8'h01, 1'b0, 16'd2);
      add(1'b1, 8'h00, 1'b1, 1'b1,  1'b1, 1'b1, 1'b0,  1'b1, 8'h07, 1'b1, 16'd3);
      add(1'b0, 8'h00, 1'b0, 1'b1,  1'b0, 1'b0, 1'b1,  1'b1, 8'h00, 1'b0, 16'd3);
      add(1'b0, 8'h00, 1'b0, 1'b1,  1'b1, 1'b0, 1'b0,  1'b1, 8'h00, 1'b1, 16'd4);
      add(1'b0, 8'h00, 1'b0, 1'b1,  1'b1, 1'b0, 1'b0,  1'b0, 8'h00, 1'b0, 16'd4);

      // Reset with s_valid high.
      rst_ni    = 1'b0;
      s_valid_i = 1'b1;
      s_data_i  = 8'h31;
      s_last_i  = 1'b0;
      m_ready_i = 1'b1;
      repeat (3) cyc();
      chk("rst_m_valid", 32'(m_valid_o), 32'd0);
      chk("rst_m_data", 32'(m_data_o), 32'd0);
      chk("rst_m_last", 32'(m_last_o), 32'd0);
      chk("rst_count", 32'(frame_count_o), 32'd0);
      chk("rst_s_ready", 32'(s_ready_o), 32'd0);
      chk("rst_crc_valid", 32'(crc_valid_o), 32'd0);
      chk("rst_crc_clear", 32'(crc_clear_o), 32'd1);
      rst_ni = 1'b1;
      #4;
      chk("init_crc_clear", 32'(crc_clear_o), 32'd1);
      chk("init_s_ready", 32'(s_ready_o), 32'd0);
      chk("init_crc_valid", 32'(crc_valid_o), 32'd0);
      cyc();

      // Table-driven vectors.
      for (int i = 0; i < tv.size(); i++) begin
         s_valid_i = tv[i].v;
         s_data_i  = tv[i].d;
         s_last_i  = tv[i].l;
         m_ready_i = tv[i].r;
         #4;
         chk($sformatf("v%0d_s_ready", i), 32'(s_ready_o), 32'(tv[i].e_rdy));
         chk($sformatf("v%0d_crc_valid", i), 32'(crc_valid_o), 32'(tv[i].e_cv));
         chk($sformatf("v%0d_crc_clear", i), 32'(crc_clear_o), 32'(tv[i].e_clr));
         chk($sformatf("v%0d_m_valid", i), 32'(m_valid_o), 32'(tv[i].e_mv));
         chk($sformatf("v%0d_count", i), 32'(frame_count_o), 32'(tv[i].e_cnt));
         if (tv[i].e_mv) begin
            chk($sformatf("v%0d_m_data", i), 32'(m_data_o), 32'(tv[i].e_md));
            chk($sformatf("v%0d_m_last", i), 32'(m_last_o), 32'(tv[i].e_ml));
         end
         if (tv[i].e_cv) begin
            chk($sformatf("v%0d_crc_data", i), 32'(crc_data_o), 32'(tv[i].d));
         end
         cyc();
      end

      // Stall in CRC state for 5 cycles after the last byte.
      clr_pulses = 0;
      s_valid_i  = 1'b1;
      s_data_i   = 8'hFF;
      s_last_i   = 1'b1;
      m_ready_i  = 1'b1;
      #4;
      chk("stall_accept", 32'(s_ready_o), 32'd1);
      if (crc_clear_o) clr_pulses++;
      cyc();
      s_valid_i = 1'b0;
      s_last_i  = 1'b0;
      m_ready_i = 1'b0;
      for (int k = 0; k < 5; k++) begin
         #4;
         chk("stall_crc_clear", 32'(crc_clear_o), 32'd0);
         chk("stall_s_ready", 32'(s_ready_o), 32'd0);
         chk("stall_m_valid", 32'(m_valid_o), 32'd1);
         chk("stall_m_data", 32'(m_data_o), 32'hFF);
         if (crc_clear_o) clr_pulses++;
         cyc();
      end
      m_ready_i = 1'b1;
      #4;
      chk("stall_load_clear", 32'(crc_clear_o), 32'd1);
      if (crc_clear_o) clr_pulses++;
      cyc();
      #4;
      chk("stall_crc_beat", 32'(m_data_o), 32'hF3);
      chk("stall_crc_last", 32'(m_last_o), 32'd1);
      chk("stall_crc_valid", 32'(m_valid_o), 32'd1);
      if (crc_clear_o) clr_pulses++;
      cyc();
      chk("stall_clear_pulses", 32'(clr_pulses), 32'd1);
      chk("stall_count", 32'(frame_count_o), 32'd5);
      chk("stall_drained", 32'(m_valid_o), 32'd0);

      // Random frames with random input gaps and downstream stalls.
      rcrc          = 8'h00;
      rem           = int'($urandom_range(8, 1));
      frames_driven = 0;
      cycles        = 0;
      acc           = 1'b0;
      prev_stall    = 1'b0;
      prev_d        = 8'h00;
      prev_l        = 1'b0;
      while (((frames_driven < 200) || (sb.size() != 0)) && (cycles < 20000)) begin
         if (!s_valid_i || acc) begin
            if ((frames_driven < 200) && ($urandom_range(9, 0) < 7)) begin
               s_valid_i = 1'b1;
               s_data_i  = 8'($urandom);
               s_last_i  = (rem == 1);
            end else begin
               s_valid_i = 1'b0;
               s_last_i  = 1'b0;
            end
         end
         m_ready_i = (frames_driven < 200) ? 1'($urandom_range(1, 0)) : 1'b1;
         #4;
         if (prev_stall) begin
            chk("rnd_stall_valid", 32'(m_valid_o), 32'd1);
            chk("rnd_stall_data", 32'(m_data_o), 32'(prev_d));
            chk("rnd_stall_last", 32'(m_last_o), 32'(prev_l));
         end
         if (m_valid_o && m_ready_i) begin
            if (sb.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL rnd_extra_beat: got data 0x%0h with no beat expected", m_data_o);
            end else begin
               beat = sb.pop_front();
               chk("rnd_data", 32'(m_data_o), 32'(beat[7:0]));
               chk("rnd_last", 32'(m_last_o), 32'(beat[8]));
            end
         end
         acc = s_valid_i && s_ready_o;
         if (acc) begin
            sb.push_back({1'b0, s_data_i});
            rcrc = crc8_upd(rcrc, s_data_i);
            rem--;
            if (s_last_i) begin
               sb.push_back({1'b1, rcrc});
               rcrc = 8'h00;
               frames_driven++;
               rem = int'($urandom_range(8, 1));
            end
         end
         prev_stall = m_valid_o && !m_ready_i;
         prev_d     = m_data_o;
         prev_l     = m_last_o;
         cyc();
         cycles++;
      end
      if (cycles >= 20000) begin
         n_checks++;
         n_fail++;
         $display("FAIL rnd_timeout: got %0d frames %0d pending expected 200 frames 0 pending",
                  frames_driven, sb.size());
      end
      chk("rnd_pending", 32'(sb.size()), 32'd0);
      chk("rnd_count", 32'(frame_count_o), 32'd205);
      s_valid_i = 1'b0;
      s_last_i  = 1'b0;
      m_ready_i = 1'b1;
      cyc();

      // Reset after 3 bytes of a 6-byte frame.
      for (int k = 0; k < 3; k++) begin
         s_valid_i = 1'b1;
         s_data_i  = 8'(8'h10 * (k + 1));
         s_last_i  = 1'b0;
         #4;
         chk("mid_accept", 32'(s_ready_o), 32'd1);
         cyc();
      end
      s_valid_i = 1'b0;
      #1;
      chk("mid_pre_valid", 32'(m_valid_o), 32'd1);
      rst_ni = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(m_valid_o), 32'd0);
      chk("mid_rst_data", 32'(m_data_o), 32'd0);
      chk("mid_rst_count", 32'(frame_count_o), 32'd0);
      chk("mid_rst_clear", 32'(crc_clear_o), 32'd1);
      repeat (2) cyc();
      rst_ni = 1'b1;
      #4;
      chk("mid_init_ready", 32'(s_ready_o), 32'd0);
      cyc();
      s_valid_i = 1'b1;
      s_data_i  = 8'h01;
      s_last_i  = 1'b1;
      #4;
      chk("mid_new_accept", 32'(s_ready_o), 32'd1);
      cyc();
      s_valid_i = 1'b0;
      s_last_i  = 1'b0;
      #4;
      chk("mid_new_data", 32'(m_data_o), 32'h01);
      chk("mid_new_data_last", 32'(m_last_o), 32'd0);
      cyc();
      #4;
      chk("mid_new_crc", 32'(m_data_o), 32'h07);
      chk("mid_new_crc_last", 32'(m_last_o), 32'd1);
      chk("mid_new_crc_valid", 32'(m_valid_o), 32'd1);
      chk("mid_new_count", 32'(frame_count_o), 32'd1);
      cyc();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
